alu_rr_arbiter: RTL and testbench

- Shares one registered 8-bit ALU datapath (add/sub plus logic ops) between NREQ independent requesters.
- Round-robin arbitration; one operation issued per cycle; single-entry output register with valid/ready backpressure.
- Each result is tagged with the requester index so the consumer can route it back.
- Sits between requester front-ends and a shared result bus; throughput 1 op/cycle when unstalled.

---
 rtl/alu_rr_pkg.sv | 21 ++
 rtl/alu_rr_exec.sv | 44 ++++
 rtl/alu_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_pkg.sv
// alu_rr_pkg
// Shared definitions for the round-robin ALU arbiter slice:
//   - opcode encodings understood by alu_rr_exec
//   - width of the optional per-requester issue counters
//   - op_is_defined(): true for opcodes that produce a real result
package alu_rr_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSA = 4'd5;

    localparam int STAT_W = 16;

    function automatic logic op_is_defined(input logic [3:0] op);
        return (op <= OP_PASSA);
    endfunction

endpackage

// File: rtl/alu_rr_exec.sv
// alu_rr_exec
// Purely combinational W-bit ALU used by alu_rr_arbiter.
// Ports:
//   a, b   in  W  operands (zero-extended to W+1 bits internally)
//   op     in  4  opcode (see alu_rr_pkg)
//   data   out W  low W bits of the result
//   carry  out 1  bit W of the ADD/SUB result (borrow for SUB), 0 otherwise
//   err    out 1  opcode undefined; data and carry are forced to 0
module alu_rr_exec
    import alu_rr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic [W-1:0] data,
    output logic         carry,
    output logic         err
);

    logic [W:0] tmp;

    always_comb begin
        tmp = '0;
        err = 1'b0;
        case (op)
            OP_ADD:   tmp = {1'b0, a} + {1'b0, b};
            // Wraps modulo 2^(W+1), so tmp[W] is set exactly when b > a.
            OP_SUB:   tmp = {1'b0, a} - {1'b0, b};
            OP_AND:   tmp = {1'b0, a & b};
            OP_OR:    tmp = {1'b0, a | b};
            OP_XOR:   tmp = {1'b0, a ^ b};
            OP_PASSA: tmp = {1'b0, a};
            default:  tmp = '0;
        endcase
        if (!op_is_defined(op)) begin
            err = 1'b1;
        end
        data  = tmp[W-1:0];
        carry = tmp[W];
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
// Shares one registered ALU between NREQ requesters using round-robin
// arbitration, one issue per cycle, with a single-entry valid/ready output
// register. Each result carries the index of the requester that issued it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  NREQ    per-requester request valid
//   req_ready    out NREQ    per-requester accept (combinational, one-hot or 0)
//   req_a/req_b  in  NREQ*W  flattened operands, requester i at [i*W +: W]
//   req_op       in  NREQ*4  flattened opcodes, requester i at [i*4 +: 4]
//   resp_valid   out 1       output register holds a result
//   resp_ready   in  1       consumer accepts the result
//   resp_data    out W       result
//   resp_carry   out 1       carry/borrow of ADD/SUB
//   resp_id      out IDW     requester that issued the result
//   resp_err     out 1       opcode was undefined
// Optional (macro ALU_RR_ARBITER_STATS_EN):
//   stat_clr     in  1       synchronous clear of all issue counters
//   stat_issued  out NREQ*16 saturating per-requester accepted-request counts
module alu_rr_arbiter
    import alu_rr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_data,
    output logic              resp_carry,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [NREQ*STAT_W-1:0] stat_issued
`endif
);

    localparam int unsigned NREQ_U = NREQ;

    logic           issue_en;
    logic           issue;
    logic           grant_found;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [3:0]     sel_op;
    logic [W-1:0]   alu_data;
    logic           alu_carry;
    logic           alu_err;

    assign issue_en = !resp_valid || resp_ready;

    // Round-robin scan starting just after the last granted requester.
    // The selected requester's operands are muxed out in the same pass.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant       = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_op      = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = 32'(last) + k;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            cand = IDW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
                sel_a       = req_a[idx*W +: W];
                sel_b       = req_b[idx*W +: W];
                sel_op      = req_op[idx*4 +: 4];
            end
        end
    end

    // Accept is held off during reset so nothing is handed over while the
    // output register is being cleared.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            req_ready[i] = rst_n && issue_en && grant_found && (grant == IDW'(i));
        end
    end

    assign issue = |(req_valid & req_ready);

    alu_rr_exec #(
        .W(W)
    ) u_exec (
        .a    (sel_a),
        .b    (sel_b),
        .op   (sel_op),
        .data (alu_data),
        .carry(alu_carry),
        .err  (alu_err)
    );

    // An issue in the same cycle as a pop simply overwrites the entry,
    // giving one result per cycle when the consumer never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            last       <= IDW'(NREQ - 1);
        end else if (issue) begin
            resp_valid <= 1'b1;
            resp_data  <= alu_data;
            resp_carry <= alu_carry;
            resp_id    <= grant;
            resp_err   <= alu_err;
            last       <= grant;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NREQ];

    // Clear has priority over a same-cycle increment; counters stick at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (issue && (stat_cnt[grant] != '1)) begin
            stat_cnt[grant] <= stat_cnt[grant] + 1'b1;
        end
    end

    always_comb begin
        stat_issued = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            stat_issued[i*STAT_W +: STAT_W] = stat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter
// Self-checking bench for alu_rr_arbiter (NREQ=4, W=8, IDW=2): directed
// reset / round-robin / arithmetic-edge / backpressure / skip-idle cases,
// then randomized traffic compared against a behavioural model.
// Stats checks are compiled in when ALU_RR_ARBITER_STATS_EN is defined.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [15:0] req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic        resp_carry;
    logic [1:0]  resp_id;
    logic        resp_err;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_issued;
`endif

    int n_checks;
    int n_errors;

    alu_rr_arbiter #(
        .NREQ(4),
        .W   (8),
        .IDW (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
`ifdef ALU_RR_ARBITER_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_issued(stat_issued)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input int a, input int b, input int op,
                                    output int d, output int c, output int e);
        d = 0;
        c = 0;
        e = 0;
        case (op)
            0: begin d = (a + b) % 256;       c = (a + b) > 255; end
            1: begin d = (a - b + 256) % 256; c = (a < b);       end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = a;
            default: e = 1;
        endcase
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_a[i*8 +: 8]  = 8'(a);
        req_b[i*8 +: 8]  = 8'(b);
        req_op[i*4 +: 4] = 4'(op);
    endtask

    // Requester i: a = 16*i, b = i+1, ADD -> result 17*i+1
    task automatic load_rr_ops();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 16 * i, i + 1, 0);
        end
    endtask

    task automatic arith(input string tag, input int a, input int b, input int op,
                         input int ed, input int ec, input int ee);
        @(negedge clk);
        set_req(0, a, b, op);
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_data"},  64'(resp_data),  64'(ed));
        check({tag, "_carry"}, 64'(resp_carry), 64'(ec));
        check({tag, "_err"},   64'(resp_err),   64'(ee));
    endtask

    // Random-phase state: pending requests and model of the output register
    int pv [4];
    int pa [4];
    int pb [4];
    int pop[4];
    int m_last, m_valid, m_data, m_carry, m_err, m_id;

    initial begin
        int g, found, en, exp_ready, d, c, e, held;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
`ifdef ALU_RR_ARBITER_STATS_EN
        stat_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Hold a result, then reset mid-operation
        @(negedge clk);
        set_req(0, 1, 2, 0);
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check("held_valid", 64'(resp_valid), 64'd1);
        check("held_data",  64'(resp_data),  64'd3);
        req_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_data",  64'(resp_data),  64'd0);
        check("rst_carry", 64'(resp_carry), 64'd0);
        check("rst_id",    64'(resp_id),    64'd0);
        check("rst_err",   64'(resp_err),   64'd0);
        check("rst_ready", 64'(req_ready),  64'd0);
`ifdef ALU_RR_ARBITER_STATS_EN
        check("rst_stats", stat_issued, 64'd0);
`endif

        // Round robin from reset: 0,1,2,3,0,1,2,3
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        load_rr_ops();
        #1 check("first_grant", 64'(req_ready), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_valid", 64'(resp_valid), 64'd1);
            check("rr_id",    64'(resp_id),    64'(k % 4));
            check("rr_data",  64'(resp_data),  64'(17 * (k % 4) + 1));
        end
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("pop_clears", 64'(resp_valid), 64'd0);

        // Arithmetic boundaries
        arith("add_wrap",  8'hFF, 8'h01, 0, 8'h00, 1, 0);
        arith("sub_borrow", 8'h00, 8'h01, 1, 8'hFF, 1, 0);
        arith("sub_plain", 8'h05, 8'h03, 1, 8'h02, 0, 0);
        arith("bad_op",    8'h5A, 8'hA5, 9, 8'h00, 0, 1);
        arith("xor",       8'h5A, 8'hFF, 4, 8'hA5, 0, 0);

        // Backpressure: last=0, all requesting, consumer stalled
        @(negedge clk);
        check("drained", 64'(resp_valid), 64'd0);
        load_rr_ops();
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        #1 check("bp_grant", 64'(req_ready), 64'b0010);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_id",    64'(resp_id),    64'd1);
            check("bp_data",  64'(resp_data),  64'd18);
            check("bp_ready", 64'(req_ready),  64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1 check("bp_next_grant", 64'(req_ready), 64'b0100);
        @(posedge clk);
        @(negedge clk);
        check("bp_next_id",   64'(resp_id),   64'd2);
        check("bp_next_data", 64'(resp_data), 64'd35);

        // Skip idle requesters: move pointer to 1, then 0001 -> 0, 1001 -> 3
        req_valid = 4'b0010;
        #1 check("skip_setup", 64'(req_ready), 64'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 check("skip_to_0", 64'(req_ready), 64'b0001);
        @(posedge clk);
        @(negedge clk);
        check("skip_id0", 64'(resp_id), 64'd0);
        req_valid = 4'b1001;
        #1 check("skip_to_3", 64'(req_ready), 64'b1000);
        @(posedge clk);
        @(negedge clk);
        check("skip_id3",   64'(resp_id),   64'd3);
        check("skip_data3", 64'(resp_data), 64'd52);
        req_valid = 4'b0000;

`ifdef ALU_RR_ARBITER_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_cleared", stat_issued, 64'd0);
        req_valid = 4'b0100;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 4'b0000;
        check("stat_req2", 64'(stat_issued[32 +: 16]), 64'd5);
        check("stat_req0", 64'(stat_issued[0 +: 16]),  64'd0);
        req_valid = 4'b0100;
        stat_clr  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        stat_clr  = 1'b0;
        check("stat_clr_wins", 64'(stat_issued[32 +: 16]), 64'd0);
`endif

        // Randomized traffic against the model, from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_last  = 3;
        m_valid = 0;
        m_data  = 0;
        m_carry = 0;
        m_err   = 0;
        m_id    = 0;
        for (int i = 0; i < 4; i++) pv[i] = 0;
        held = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (pv[i] == 0 && ($urandom % 3) != 0) begin
                    pv[i]  = 1;
                    pa[i]  = $urandom_range(0, 255);
                    pb[i]  = $urandom_range(0, 255);
                    pop[i] = ($urandom % 5 == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
                end
                req_valid[i] = (pv[i] != 0);
                set_req(i, pa[i], pb[i], pop[i]);
            end
            resp_ready = ($urandom % 4) != 0;
            #1;
            en    = (m_valid == 0) || resp_ready;
            found = 0;
            g     = 0;
            for (int k = 1; k <= 4; k++) begin
                if (found == 0 && pv[(m_last + k) % 4] != 0) begin
                    found = 1;
                    g     = (m_last + k) % 4;
                end
            end
            exp_ready = (en != 0 && found != 0) ? (1 << g) : 0;
            check("rnd_ready", 64'(req_ready),  64'(exp_ready));
            check("rnd_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid != 0) begin
                check("rnd_data",  64'(resp_data),  64'(m_data));
                check("rnd_carry", 64'(resp_carry), 64'(m_carry));
                check("rnd_err",   64'(resp_err),   64'(m_err));
                check("rnd_id",    64'(resp_id),    64'(m_id));
            end
            if (m_valid != 0 && !resp_ready) held++;
            if (en != 0 && found != 0) begin
                alu_ref(pa[g], pb[g], pop[g], d, c, e);
                m_valid = 1;
                m_data  = d;
                m_carry = c;
                m_err   = e;
                m_id    = g;
                m_last  = g;
                pv[g]   = 0;
            end else if (resp_ready) begin
                m_valid = 0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("rnd_saw_stall", 64'(held > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
